// File: rtl/soc_system_theta_pkg.sv
// Shared types and constants for the theta-clock PLL phase stepper.
// Register map and DPS word layout of the PLL reconfig management port.
`timescale 1ns/1ps
package soc_system_theta_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_DPS,
    ST_WR_START,
    ST_POLL,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_SAMPLE
  } state_e;

  localparam int unsigned MGMT_AW = 6;
  localparam int unsigned MGMT_DW = 32;

  localparam logic [MGMT_AW-1:0] ADDR_MODE   = 6'h00;
  localparam logic [MGMT_AW-1:0] ADDR_STATUS = 6'h01;
  localparam logic [MGMT_AW-1:0] ADDR_START  = 6'h02;
  localparam logic [MGMT_AW-1:0] ADDR_DPS    = 6'h06;

  localparam logic [MGMT_DW-1:0] MODE_POLLING = 32'd1;

  localparam int unsigned DPS_CNT_LSB  = 0;
  localparam int unsigned DPS_CNT_W    = 16;
  localparam int unsigned DPS_CHAN_LSB = 16;
  localparam int unsigned DPS_CHAN_W   = 5;
  localparam int unsigned DPS_DIR_BIT  = 21;

  typedef struct packed {
    logic                we;
    logic [MGMT_AW-1:0]  addr;
    logic [MGMT_DW-1:0]  wdata;
  } mgmt_req_t;

  // Assemble the dynamic-phase-shift register word.
  function automatic logic [MGMT_DW-1:0] dps_word(input logic                  dir,
                                                  input logic [DPS_CHAN_W-1:0] chan,
                                                  input logic [DPS_CNT_W-1:0]  cnt);
    logic [MGMT_DW-1:0] w;
    w = '0;
    w[DPS_CNT_LSB +: DPS_CNT_W]   = cnt;
    w[DPS_CHAN_LSB +: DPS_CHAN_W] = chan;
    w[DPS_DIR_BIT]                = dir;
    return w;
  endfunction

endpackage

// File: rtl/soc_system_theta_mgmt_master.sv
// Single-outstanding Avalon-MM read/write engine for the reconfig management port.
// A request is taken only while idle; done_c marks the cycle the slave accepts it.
`timescale 1ns/1ps
module soc_system_theta_mgmt_master
  import soc_system_theta_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid_i,
  input  mgmt_req_t          req_i,
  output logic               ready_c,
  output logic               done_c,
  output logic [MGMT_DW-1:0] rdata_c,
  output logic [MGMT_AW-1:0] mgmt_address_o,
  output logic               mgmt_read_o,
  output logic               mgmt_write_o,
  output logic [MGMT_DW-1:0] mgmt_writedata_o,
  input  logic [MGMT_DW-1:0] mgmt_readdata_i,
  input  logic               mgmt_waitrequest_i
);

  logic [MGMT_AW-1:0] addr_q;
  logic               rd_q;
  logic               wr_q;
  logic [MGMT_DW-1:0] wdata_q;
  logic               active_c;

  assign active_c = rd_q | wr_q;
  assign ready_c  = ~active_c;
  assign done_c   = active_c & ~mgmt_waitrequest_i;
  assign rdata_c  = mgmt_readdata_i;

  // Strobes and payload hold until the slave drops waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (done_c) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else if (req_valid_i && ready_c) begin
      addr_q  <= req_i.addr;
      wr_q    <= req_i.we;
      rd_q    <= ~req_i.we;
      wdata_q <= req_i.wdata;
    end
  end

  assign mgmt_address_o   = addr_q;
  assign mgmt_read_o      = rd_q;
  assign mgmt_write_o     = wr_q;
  assign mgmt_writedata_o = wdata_q;

endmodule

// File: rtl/soc_system_theta_phase_stepper.sv
// Theta-clock PLL phase stepper: sequences DPS writes, status polling, lock wait and
// settling on the reconfig core, tracks per-channel phase and paces TDC sweep samples.
`timescale 1ns/1ps
module soc_system_theta_phase_stepper
  import soc_system_theta_pkg::*;
#(
  parameter int unsigned NUM_CLKS       = 2,
  parameter int unsigned STEP_W         = 16,
  parameter int unsigned PH_STEPS       = 128,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned PH_W           = $clog2(PH_STEPS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [$clog2(NUM_CLKS+1)-1:0] cmd_chan,
  input  logic [STEP_W-1:0]           cmd_steps,
  input  logic                        cmd_dir,
  input  logic                        cmd_sweep,
  input  logic                        pll_locked,
  output logic [MGMT_AW-1:0]          mgmt_address,
  output logic                        mgmt_read,
  output logic                        mgmt_write,
  output logic [MGMT_DW-1:0]          mgmt_writedata,
  input  logic [MGMT_DW-1:0]          mgmt_readdata,
  input  logic                        mgmt_waitrequest,
  output logic                        sample_req,
  input  logic                        sample_ack,
  output logic [NUM_CLKS*PH_W-1:0]    phase_out,
  output logic                        busy,
  output logic                        err_timeout,
  output logic                        err_badchan
);

  // cmd_chan carries one code beyond the last counter so bad requests are representable.
  localparam int unsigned CHAN_W = $clog2(NUM_CLKS+1);
  localparam int unsigned PH_W1  = PH_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES+1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES+1);

  state_e              state_q, state_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic                dir_q, dir_d;
  logic                sweep_q, sweep_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [TMO_W-1:0]    timer_q, timer_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [PH_W-1:0]     phase_q [NUM_CLKS];
  logic [PH_W-1:0]     phase_d [NUM_CLKS];
  logic                err_timeout_q, err_timeout_d;
  logic                err_badchan_q, err_badchan_d;
  logic                cmd_ready_q, busy_q, sample_req_q;

  logic                req_valid_c;
  mgmt_req_t           req_c;
  logic                mm_ready_c, mm_done_c;
  logic [MGMT_DW-1:0]  mm_rdata_c;
  logic [STEP_W-1:0]   shot_n_c;
  logic                unused_rdata_c;

  assign unused_rdata_c = ^mm_rdata_c[MGMT_DW-1:1];
  assign shot_n_c       = sweep_q ? STEP_W'(1) : remaining_q;

  // Exact (phase +/- n) mod PH_STEPS for any n, without relying on PH_STEPS being 2^k.
  function automatic logic [PH_W-1:0] phase_step(input logic [PH_W-1:0]   ph,
                                                 input logic [STEP_W-1:0] n,
                                                 input logic              up);
    logic [STEP_W-1:0] nm;
    logic [PH_W1-1:0]  s;
    nm = n % STEP_W'(PH_STEPS);
    if (up) begin
      s = {1'b0, ph} + PH_W1'(nm);
      if (s >= PH_W1'(PH_STEPS)) s = s - PH_W1'(PH_STEPS);
    end else if ({1'b0, ph} >= PH_W1'(nm)) begin
      s = {1'b0, ph} - PH_W1'(nm);
    end else begin
      s = {1'b0, ph} + PH_W1'(PH_STEPS) - PH_W1'(nm);
    end
    return PH_W'(s);
  endfunction

  soc_system_theta_mgmt_master u_mgmt (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid_i        (req_valid_c),
    .req_i              (req_c),
    .ready_c            (mm_ready_c),
    .done_c             (mm_done_c),
    .rdata_c            (mm_rdata_c),
    .mgmt_address_o     (mgmt_address),
    .mgmt_read_o        (mgmt_read),
    .mgmt_write_o       (mgmt_write),
    .mgmt_writedata_o   (mgmt_writedata),
    .mgmt_readdata_i    (mgmt_readdata),
    .mgmt_waitrequest_i (mgmt_waitrequest)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    chan_d        = chan_q;
    dir_d         = dir_q;
    sweep_d       = sweep_q;
    remaining_d   = remaining_q;
    timer_d       = timer_q;
    settle_d      = settle_q;
    phase_d       = phase_q;
    err_timeout_d = err_timeout_q;
    err_badchan_d = 1'b0;
    req_valid_c   = 1'b0;
    req_c         = '0;

    case (state_q)
      ST_INIT: begin
        req_c       = '{we: 1'b1, addr: ADDR_MODE, wdata: MODE_POLLING};
        req_valid_c = mm_ready_c;
        if (mm_done_c) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          err_timeout_d = 1'b0;
          if (cmd_chan >= CHAN_W'(NUM_CLKS)) begin
            err_badchan_d = 1'b1;
          end else if (cmd_steps != '0) begin
            chan_d      = cmd_chan;
            dir_d       = cmd_dir;
            sweep_d     = cmd_sweep;
            remaining_d = cmd_steps;
            state_d     = ST_WR_DPS;
          end
        end
      end

      ST_WR_DPS: begin
        req_c       = '{we: 1'b1, addr: ADDR_DPS,
                        wdata: dps_word(dir_q, DPS_CHAN_W'(chan_q), DPS_CNT_W'(shot_n_c))};
        req_valid_c = mm_ready_c;
        if (mm_done_c) state_d = ST_WR_START;
      end

      ST_WR_START: begin
        req_c       = '{we: 1'b1, addr: ADDR_START, wdata: '0};
        req_valid_c = mm_ready_c;
        if (mm_done_c) begin
          timer_d = '0;
          state_d = ST_POLL;
        end
      end

      ST_POLL: begin
        req_c       = '{we: 1'b0, addr: ADDR_STATUS, wdata: '0};
        req_valid_c = mm_ready_c;
        timer_d     = timer_q + TMO_W'(1);
        if (mm_done_c && mm_rdata_c[0]) begin
          for (int k = 0; k < NUM_CLKS; k++) begin
            if (chan_q == CHAN_W'(k)) phase_d[k] = phase_step(phase_q[k], shot_n_c, dir_q);
          end
          timer_d = '0;
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_WAIT_LOCK: begin
        timer_d = timer_q + TMO_W'(1);
        if (pll_locked) begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (!pll_locked) begin
          settle_d = '0;
        end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = sweep_q ? ST_SAMPLE : ST_IDLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (sample_ack) begin
          remaining_d = remaining_q - STEP_W'(1);
          state_d     = (remaining_q == STEP_W'(1)) ? ST_IDLE : ST_WR_DPS;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // Command fields, counters, accumulators and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q        <= '0;
      dir_q         <= 1'b0;
      sweep_q       <= 1'b0;
      remaining_q   <= '0;
      timer_q       <= '0;
      settle_q      <= '0;
      for (int k = 0; k < NUM_CLKS; k++) phase_q[k] <= '0;
      err_timeout_q <= 1'b0;
      err_badchan_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      sample_req_q  <= 1'b0;
    end else begin
      chan_q        <= chan_d;
      dir_q         <= dir_d;
      sweep_q       <= sweep_d;
      remaining_q   <= remaining_d;
      timer_q       <= timer_d;
      settle_q      <= settle_d;
      phase_q       <= phase_d;
      err_timeout_q <= err_timeout_d;
      err_badchan_q <= err_badchan_d;
      cmd_ready_q   <= (state_d == ST_IDLE);
      busy_q        <= (state_d != ST_IDLE) && (state_d != ST_INIT);
      sample_req_q  <= (state_d == ST_SAMPLE);
    end
  end

  for (genvar k = 0; k < NUM_CLKS; k++) begin : g_phase_out
    assign phase_out[k*PH_W +: PH_W] = phase_q[k];
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign sample_req  = sample_req_q;
  assign err_timeout = err_timeout_q;
  assign err_badchan = err_badchan_q;

endmodule
